// File: rtl/mbt_pixel_sched.sv
// mbt_pixel_sched: walks an H_RES x V_RES grid of complex coordinates, hands each one
// to an escape-time ALU, and offers the returned iteration count as a pixel write.
// Optional build macro MBT_SCHED_TIMEOUT_EN adds a WAIT watchdog that drives err.
module mbt_pixel_sched #(
  parameter int N      = 32,
  parameter int Q      = 21,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [N-1:0]      x_min,
  input  logic [N-1:0]      y_max,
  input  logic [N-1:0]      step,
  output logic              busy,
  output logic              done,
  output logic              alu_rst,
  output logic              alu_start,
  output logic [N-1:0]      alu_c_real,
  output logic [N-1:0]      alu_c_img,
  input  logic              alu_valid,
  input  logic [6:0]        alu_d_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [6:0]        pix_data,
  output logic              err
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  // Q only describes the coordinate format; the scheduler just adds and subtracts words.
  if (Q >= N) begin : g_bad_q
    $error("mbt_pixel_sched: Q must be smaller than N");
  end
  if ((64'd1 << ADDR_W) < 64'(H_RES * V_RES)) begin : g_bad_addr_w
    $error("mbt_pixel_sched: ADDR_W too small for H_RES*V_RES");
  end

  typedef enum logic [2:0] {IDLE, SETUP, ARST, ASTART, WAIT, EMIT, FIN} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [N-1:0]        x_min_q, step_q, c_real_q, c_img_q;
  logic [6:0]          data_q;
  logic                last_x, last_pix, timeout;

  assign last_x   = (x_q == XW'(H_RES - 1));
  assign last_pix = last_x && (y_q == YW'(V_RES - 1));

  // State register; reset is synchronous and wins from any state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for the per-pixel handshake sequence.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = SETUP;
      SETUP:   state_d = ARST;
      ARST:    state_d = ASTART;
      ASTART:  state_d = WAIT;
      WAIT:    if (alu_valid || timeout) state_d = EMIT;
      EMIT:    if (pix_ready) state_d = last_pix ? FIN : ARST;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coordinate walk, address counter and pixel capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      x_min_q  <= '0;
      step_q   <= '0;
      c_real_q <= '0;
      c_img_q  <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        SETUP: begin
          x_min_q  <= x_min;
          step_q   <= step;
          x_q      <= '0;
          y_q      <= '0;
          addr_q   <= '0;
          c_real_q <= x_min;
          c_img_q  <= y_max;
        end
        WAIT: begin
          if (alu_valid)    data_q <= alu_d_out;
          else if (timeout) data_q <= 7'd127;
        end
        EMIT: begin
          if (pix_ready && !last_pix) begin
            addr_q <= addr_q + 1'b1;
            if (!last_x) begin
              x_q      <= x_q + 1'b1;
              c_real_q <= c_real_q + step_q;
            end else begin
              x_q      <= '0;
              y_q      <= y_q + 1'b1;
              c_real_q <= x_min_q;
              c_img_q  <= c_img_q - step_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MBT_SCHED_TIMEOUT_EN
  logic [9:0] wd_q;
  logic       err_q;

  // Give up on the 1023rd consecutive WAIT cycle without alu_valid.
  assign timeout = (state_q == WAIT) && !alu_valid && (wd_q == 10'd1022);
  assign err     = err_q;

  // Watchdog counts WAIT cycles; err is sticky until reset or the next frame setup.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ASTART)    wd_q <= '0;
      else if (state_q == WAIT) wd_q <= wd_q + 10'd1;
      if (state_q == SETUP)     err_q <= 1'b0;
      else if (timeout)         err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign alu_rst    = rst || (state_q == ARST);
  assign alu_start  = (state_q == ASTART);
  assign pix_valid  = (state_q == EMIT);
  assign pix_addr   = addr_q;
  assign pix_data   = data_q;
  assign alu_c_real = c_real_q;
  assign alu_c_img  = c_img_q;

endmodule
